// File: rtl/cpu_mem_loader.sv
// Loads CPU instruction/data memories from a valid/ready word stream, verifies them by checksum readback,
// then enables the CPU; writes land one cycle after acceptance, s_ready is high only in the load phases.
module cpu_mem_loader #(
    parameter int DATA_W     = 32,
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int LEN_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  imem_len,
    input  logic [LEN_W-1:0]  dmem_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic [1:0]        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RDBK_I, S_RDBK_D, S_CHECK, S_RUN, S_ERROR
    } state_t;

    localparam logic [LEN_W-1:0] IMAX = LEN_W'(IMEM_WORDS);
    localparam logic [LEN_W-1:0] DMAX = LEN_W'(DMEM_WORDS);
    localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

    state_t             r_state, w_nxt_state;
    logic [LEN_W-1:0]   r_ilen, w_nxt_ilen;
    logic [LEN_W-1:0]   r_dlen, w_nxt_dlen;
    logic [LEN_W-1:0]   r_cnt, w_nxt_cnt;
    logic [31:0]        r_sum_ld, w_nxt_sum_ld;
    logic [31:0]        r_sum_rb, w_nxt_sum_rb;
    logic               r_acc_i, w_nxt_acc_i;
    logic               r_acc_d, w_nxt_acc_d;
    logic [31:0]        r_addr_i, w_nxt_addr_i;
    logic [31:0]        r_addr_d, w_nxt_addr_d;
    logic               r_wen_i, w_nxt_wen_i;
    logic               r_wen_d, w_nxt_wen_d;
    logic               r_ren_i, w_nxt_ren_i;
    logic               r_ren_d, w_nxt_ren_d;
    logic [DATA_W-1:0]  r_wdata_i, w_nxt_wdata_i;
    logic [DATA_W-1:0]  r_wdata_d, w_nxt_wdata_d;
    logic               r_cpu_en, w_nxt_cpu_en;
    logic [1:0]         r_err, w_nxt_err;

    logic               w_xfer;
    logic               w_start_ok;
    logic [31:0]        w_cnt_addr;

    // Zero-length phases are skipped, so the entry state depends on which lengths are non-zero.
    function automatic state_t rdbk_entry(input logic [LEN_W-1:0] il, input logic [LEN_W-1:0] dl);
        if (il != '0)      return S_RDBK_I;
        else if (dl != '0) return S_RDBK_D;
        else               return S_CHECK;
    endfunction

    function automatic state_t load_entry(input logic [LEN_W-1:0] il, input logic [LEN_W-1:0] dl);
        if (il != '0)      return S_LOAD_I;
        else if (dl != '0) return S_LOAD_D;
        else               return rdbk_entry(il, dl);
    endfunction

    assign s_ready    = (r_state == S_LOAD_I) || (r_state == S_LOAD_D);
    assign busy       = !((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));
    assign w_xfer     = s_valid && s_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));
    assign w_cnt_addr = {{(32-LEN_W-2){1'b0}}, r_cnt, 2'b00};

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ilen    = r_ilen;
        w_nxt_dlen    = r_dlen;
        w_nxt_cnt     = r_cnt;
        w_nxt_sum_ld  = r_sum_ld;
        // Read data returns one cycle after ren, so the accumulate flags are ren delayed by one.
        w_nxt_sum_rb  = r_sum_rb + (r_acc_i ? rdata_ext : '0) + (r_acc_d ? rdata_ext_2 : '0);
        w_nxt_acc_i   = r_ren_i;
        w_nxt_acc_d   = r_ren_d;
        w_nxt_addr_i  = r_addr_i;
        w_nxt_addr_d  = r_addr_d;
        w_nxt_wen_i   = 1'b0;
        w_nxt_wen_d   = 1'b0;
        w_nxt_ren_i   = 1'b0;
        w_nxt_ren_d   = 1'b0;
        w_nxt_wdata_i = r_wdata_i;
        w_nxt_wdata_d = r_wdata_d;
        w_nxt_cpu_en  = r_cpu_en;
        w_nxt_err     = r_err;

        if (stop) begin
            w_nxt_state  = S_IDLE;
            w_nxt_cpu_en = 1'b0;
        end else if (w_start_ok) begin
            w_nxt_ilen   = imem_len;
            w_nxt_dlen   = dmem_len;
            w_nxt_cnt    = '0;
            w_nxt_sum_ld = '0;
            w_nxt_sum_rb = '0;
            w_nxt_err    = 2'd0;
            w_nxt_cpu_en = 1'b0;
            if ((imem_len > IMAX) || (dmem_len > DMAX)) begin
                w_nxt_state = S_ERROR;
                w_nxt_err   = 2'd1;
            end else begin
                w_nxt_state = load_entry(imem_len, dmem_len);
            end
        end else begin
            case (r_state)
                S_LOAD_I: begin
                    if (w_xfer) begin
                        w_nxt_wen_i   = 1'b1;
                        w_nxt_wdata_i = s_data;
                        w_nxt_addr_i  = w_cnt_addr;
                        w_nxt_sum_ld  = r_sum_ld + s_data;
                        if (r_cnt == r_ilen - ONE) begin
                            w_nxt_cnt   = '0;
                            w_nxt_state = (r_dlen != '0) ? S_LOAD_D : rdbk_entry(r_ilen, r_dlen);
                        end else begin
                            w_nxt_cnt = r_cnt + ONE;
                        end
                    end
                end
                S_LOAD_D: begin
                    if (w_xfer) begin
                        w_nxt_wen_d   = 1'b1;
                        w_nxt_wdata_d = s_data;
                        w_nxt_addr_d  = w_cnt_addr;
                        w_nxt_sum_ld  = r_sum_ld + s_data;
                        if (r_cnt == r_dlen - ONE) begin
                            w_nxt_cnt   = '0;
                            w_nxt_state = rdbk_entry(r_ilen, r_dlen);
                        end else begin
                            w_nxt_cnt = r_cnt + ONE;
                        end
                    end
                end
                S_RDBK_I: begin
                    if (r_cnt != r_ilen) begin
                        w_nxt_ren_i  = 1'b1;
                        w_nxt_addr_i = w_cnt_addr;
                        w_nxt_cnt    = r_cnt + ONE;
                    end else if (!r_ren_i) begin
                        // Drain cycle done: the final word is accumulated on this same edge.
                        w_nxt_cnt   = '0;
                        w_nxt_state = (r_dlen != '0) ? S_RDBK_D : S_CHECK;
                    end
                end
                S_RDBK_D: begin
                    if (r_cnt != r_dlen) begin
                        w_nxt_ren_d  = 1'b1;
                        w_nxt_addr_d = w_cnt_addr;
                        w_nxt_cnt    = r_cnt + ONE;
                    end else if (!r_ren_d) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_sum_ld == r_sum_rb) begin
                        w_nxt_state  = S_RUN;
                        w_nxt_cpu_en = 1'b1;
                    end else begin
                        w_nxt_state = S_ERROR;
                        w_nxt_err   = 2'd2;
                    end
                end
                S_ERROR: w_nxt_cpu_en = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ilen    <= '0;
            r_dlen    <= '0;
            r_cnt     <= '0;
            r_sum_ld  <= '0;
            r_sum_rb  <= '0;
            r_acc_i   <= 1'b0;
            r_acc_d   <= 1'b0;
            r_addr_i  <= '0;
            r_addr_d  <= '0;
            r_wen_i   <= 1'b0;
            r_wen_d   <= 1'b0;
            r_ren_i   <= 1'b0;
            r_ren_d   <= 1'b0;
            r_wdata_i <= '0;
            r_wdata_d <= '0;
            r_cpu_en  <= 1'b0;
            r_err     <= 2'd0;
        end else begin
            r_state   <= w_nxt_state;
            r_ilen    <= w_nxt_ilen;
            r_dlen    <= w_nxt_dlen;
            r_cnt     <= w_nxt_cnt;
            r_sum_ld  <= w_nxt_sum_ld;
            r_sum_rb  <= w_nxt_sum_rb;
            r_acc_i   <= w_nxt_acc_i;
            r_acc_d   <= w_nxt_acc_d;
            r_addr_i  <= w_nxt_addr_i;
            r_addr_d  <= w_nxt_addr_d;
            r_wen_i   <= w_nxt_wen_i;
            r_wen_d   <= w_nxt_wen_d;
            r_ren_i   <= w_nxt_ren_i;
            r_ren_d   <= w_nxt_ren_d;
            r_wdata_i <= w_nxt_wdata_i;
            r_wdata_d <= w_nxt_wdata_d;
            r_cpu_en  <= w_nxt_cpu_en;
            r_err     <= w_nxt_err;
        end
    end

    assign addr_ext    = r_addr_i;
    assign wen_ext     = r_wen_i;
    assign ren_ext     = r_ren_i;
    assign wdata_ext   = r_wdata_i;
    assign addr_ext_2  = r_addr_d;
    assign wen_ext_2   = r_wen_d;
    assign ren_ext_2   = r_ren_d;
    assign wdata_ext_2 = r_wdata_d;
    assign cpu_enable  = r_cpu_en;
    assign error       = r_err;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: memory models on both ports, write scoreboard, directed load scenarios.
module tb_cpu_mem_loader;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [LEN_W-1:0]  imem_len;
    logic [LEN_W-1:0]  dmem_len;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [31:0]       addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;
    logic [31:0]       addr_ext_2;
    logic              wen_ext_2;
    logic              ren_ext_2;
    logic [DATA_W-1:0] wdata_ext_2;
    logic [DATA_W-1:0] rdata_ext_2;
    logic              cpu_enable;
    logic              busy;
    logic [1:0]        error;

    always #5 clk = ~clk;

    cpu_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .imem_len(imem_len), .dmem_len(dmem_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    // Memory models: registered read, optional corruption of dmem word 1.
    logic [31:0] imem [0:511];
    logic [31:0] dmem [0:1023];
    logic        corrupt = 1'b0;

    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext)   rdata_ext <= imem[addr_ext[10:2]];
        if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= (corrupt && addr_ext_2 == 32'h4) ? 32'hC : dmem[addr_ext_2[11:2]];
    end

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_cnt = 0;
    int  rd_cnt = 0;

    logic [31:0] iw [0:2];
    logic [31:0] dw [0:1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mon_write(input logic port, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        checks++;
        wr_cnt++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected port=%0d addr=%h data=%h required=no write", port, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e !== wr_t'({port, addr, data})) begin
                errors++;
                $display("FAIL wr_compare actual port=%0d addr=%h data=%h required port=%0d addr=%h data=%h",
                         port, addr, data, e.port, e.addr, e.data);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every write pulse, counts reads, polices port exclusivity.
    always @(negedge clk) begin
        if (wen_ext)   mon_write(1'b0, addr_ext, wdata_ext);
        if (wen_ext_2) mon_write(1'b1, addr_ext_2, wdata_ext_2);
        if (ren_ext)   rd_cnt++;
        if (ren_ext_2) rd_cnt++;
        if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) begin
            checks++;
            errors++;
            $display("FAIL port_excl actual=wen&ren required=exclusive");
        end
    end

    task automatic do_start(input int il, input int dl);
        imem_len = LEN_W'(il);
        dmem_len = LEN_W'(dl);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic push(input logic port, input int idx, input logic [31:0] w, input bit toggle);
        bit ok = 1'b0;
        exp_q.push_back(wr_t'({port, 32'(idx * 4), w}));
        s_valid = 1'b1;
        s_data  = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL s_ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (toggle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
        @(posedge clk); #1;
    endtask

    task automatic full_load(input bit toggle);
        do_start(3, 2);
        for (int i = 0; i < 3; i++) push(1'b0, i, iw[i], toggle);
        for (int i = 0; i < 2; i++) push(1'b1, i, dw[i], toggle);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        iw[0] = 32'h20010005; iw[1] = 32'h20020007; iw[2] = 32'h00221820;
        dw[0] = 32'h0000000A; dw[1] = 32'h0000000B;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        imem_len = '0; dmem_len = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_addr_ext", addr_ext, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back stream
        rd0 = rd_cnt;
        full_load(1'b0);
        chk("t1_cpu_enable", cpu_enable, 1);
        chk("t1_error", error, 0);
        chk("t1_reads", rd_cnt - rd0, 5);
        chk("t1_imem0", imem[0], 32'h20010005);
        chk("t1_imem2", imem[2], 32'h00221820);
        chk("t1_dmem1", dmem[1], 32'h0000000B);

        // Gappy stream, started from RUN
        full_load(1'b1);
        chk("t2_cpu_enable", cpu_enable, 1);
        chk("t2_error", error, 0);
        chk("t2_imem1", imem[1], 32'h20020007);
        chk("t2_dmem0", dmem[0], 32'h0000000A);

        // Corrupted readback
        corrupt = 1'b1;
        full_load(1'b0);
        chk("t3_error", error, 2);
        chk("t3_cpu_enable", cpu_enable, 0);
        chk("t3_busy", busy, 0);
        corrupt = 1'b0;

        // Length overflow: no writes at all
        wr0 = wr_cnt;
        do_start(513, 2);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cpu_enable", cpu_enable, 0);
        repeat (10) @(posedge clk);
        #1;
        do_start(3, 1025);
        chk("t4_derror", error, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_writes", wr_cnt - wr0, 0);

        // Reset mid-load after the second imem word
        do_start(3, 2);
        chk("t5_error_cleared", error, 0);
        push(1'b0, 0, iw[0], 1'b0);
        push(1'b0, 1, iw[1], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_wen_ext", wen_ext, 0);
        chk("t5_s_ready", s_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_addr_ext", addr_ext, 0);
        chk("t5_wdata_ext", wdata_ext, 0);
        chk("t5_cpu_enable", cpu_enable, 0);
        chk("t5_pending_writes", exp_q.size(), 0);
        full_load(1'b0);
        chk("t5_reload_cpu_enable", cpu_enable, 1);
        chk("t5_reload_error", error, 0);

        // Stop and start together in RUN: stop wins
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        imem_len = LEN_W'(3);
        dmem_len = LEN_W'(2);
        stop  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        stop  = 1'b0;
        start = 1'b0;
        chk("t6_cpu_enable", cpu_enable, 0);
        chk("t6_busy", busy, 0);
        chk("t6_s_ready", s_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_activity", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

        // Both lengths zero go straight to RUN
        rd0 = rd_cnt;
        do_start(0, 0);
        wait_idle();
        chk("t7_cpu_enable", cpu_enable, 1);
        chk("t7_error", error, 0);
        chk("t7_reads", rd_cnt - rd0, 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
- Host-side controller that drives the CPU's two external memory ports: instruction memory (`*_ext`) and data memory (`*_ext_2`).
- Accepts a word stream over a valid/ready handshake and writes the instruction image, then the data image.
- Reads both images back and compares a running 32-bit checksum against the one accumulated during loading.
- Asserts the CPU `enable` only after the check passes. Sits between the test/host interface and the cpu top.

Parameters:
- DATA_W, 32, word width of stream and memory ports
- IMEM_WORDS, 512, instruction memory capacity in words
- DMEM_WORDS, 1024, data memory capacity in words
- LEN_W, 11, width of length inputs

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; latches lengths and begins a load
- stop  in  1  one-cycle pulse; drops cpu_enable and returns to IDLE
- imem_len  in  LEN_W  instruction words to load (0 allowed)
- dmem_len  in  LEN_W  data words to load (0 allowed)
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  DATA_W  stream word; instruction words first, then data words
- addr_ext  out  32  imem byte address (word i at 4*i)
- wen_ext  out  1  imem write enable
- ren_ext  out  1  imem read enable
- wdata_ext  out  DATA_W  imem write data
- rdata_ext  in  DATA_W  imem read data, valid the cycle after ren_ext
- addr_ext_2  out  32  dmem byte address (word i at 4*i)
- wen_ext_2  out  1  dmem write enable
- ren_ext_2  out  1  dmem read enable
- wdata_ext_2  out  DATA_W  dmem write data
- rdata_ext_2  in  DATA_W  dmem read data, valid the cycle after ren_ext_2
- cpu_enable  out  1  drives cpu enable
- busy  out  1  high in every state except IDLE, RUN, ERROR
- error  out  2  0 none, 1 length overflow, 2 checksum mismatch; sticky until next start or rst

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - All enables, s_ready, cpu_enable, busy, addresses, wdata, error, checksums and counters go to 0.
  - Applies from any state, including mid-load; no partial write occurs on that edge.
- States: IDLE, LOAD_I, LOAD_D, RDBK_I, RDBK_D, CHECK, RUN, ERROR.
- IDLE:
  - On start, latch the lengths and clear error, both checksums and the word counter.
  - If imem_len > IMEM_WORDS or dmem_len > DMEM_WORDS, go to ERROR with error=1.
  - Otherwise go to LOAD_I; a zero length skips straight to the next phase.
- start outside IDLE/RUN/ERROR is ignored. In RUN or ERROR, start behaves as in IDLE.
- LOAD_I / LOAD_D:
  - s_ready is high.
  - A word transfers on a clk edge where s_valid && s_ready.
  - That same edge registers wen=1, wdata=s_data, addr=4*count, and adds the word to the load checksum (sum mod 2^32).
  - wen is high for exactly one cycle per accepted word.
  - When count reaches len-1 with a transfer, advance to the next phase and reset count.
  - s_valid low inserts idle cycles with no write; there is no timeout.
- RDBK_I / RDBK_D:
  - s_ready is low.
  - Issue ren with addr=4*count, one read per cycle.
  - The returned word is added to the readback checksum on the following edge.
  - A one-cycle drain follows the last read before advancing.
  - Memory enables are never asserted simultaneously with wen on the same port.
- CHECK (1 cycle):
  - If checksums are equal, go to RUN with cpu_enable=1 on the next cycle.
  - Otherwise go to ERROR with error=2.
- RUN: cpu_enable stays high and all memory enables stay low. stop → IDLE, cpu_enable=0 the next cycle.
- ERROR: cpu_enable=0; leave only via start or rst.
- start and stop in the same cycle: stop has priority.
- Both lengths 0: IDLE → CHECK (sums both 0) → RUN.

Test Plan:
- Load imem_len=3 (0x20010005, 0x20020007, 0x00221820) and dmem_len=2 (0xA, 0xB) with s_valid always high → writes at imem 0x0/0x4/0x8 and dmem 0x0/0x4 on consecutive cycles; reads follow; cpu_enable=1, error=0.
- Same load with s_valid toggling every other cycle → identical memory contents; wen pulses only on accepted cycles; run reached.
- Memory model corrupts dmem word 1 on read (returns 0xC) → error=2, cpu_enable stays 0, busy=0.
- start with imem_len=513 → ERROR next cycle, error=1, no wen_ext/wen_ext_2 ever asserted.
- Assert rst after the 2nd imem word is accepted → next cycle all outputs 0, state IDLE; a subsequent full load succeeds.
- In RUN, pulse stop and start together → cpu_enable=0 next cycle and state IDLE (no reload started).
